fsqrt_op_sequencer: RTL and testbench
=====================================

Name: fsqrt_op_sequencer

Overview:
- Front-end and back-end control stage wrapped around the floating-point square-root core in the Floating ALU.
- Accepts an IEEE-754 single-precision operand over a valid/ready handshake and classifies it.
- Special operands (zero, negative, inf, NaN, denormal) are resolved locally without using the core. Normal operands launch the core, which is held enabled for a fixed latency; the result is captured and presented over a valid/ready output handshake with exception flags.

Parameters:
- CORE_LATENCY, 2: clock cycles from core_a stable with core_en=1 until core_result is valid; legal range 1..15.
- CNT_W, 4: width of the latency counter; must satisfy 2^CNT_W > CORE_LATENCY.

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous reset, active-low
- in_valid  in  1  operand valid
- in_ready  out  1  sequencer can accept an operand
- in_a  in  32  operand, IEEE-754 single
- core_en  out  1  enable to sqrt core
- core_a  out  32  operand to sqrt core
- core_result  in  32  result from sqrt core
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_result  out  32  square root, IEEE-754 single
- out_invalid  out  1  invalid operation (negative nonzero or signalling NaN)
- out_denorm  out  1  denormal input flushed to zero
- out_special  out  1  result produced by bypass, not by the core

Behaviour:
- Clock and reset: RST asynchronous, active-low; clock CLK.
- Reset values: all outputs are 0, state is IDLE, and the operand register is 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_a and classify it: exp=A[30:23], man=A[22:0], s=A[31].
  - Next state is DONE for special operands and BUSY for normal operands.
- Special classification, with the result loaded into out_result at the accept edge:
  - exp=0, man=0 (±0): result=in_a (sign preserved).
  - exp=0, man!=0: result=32'h00000000, out_denorm=1.
  - exp=255, man!=0 (NaN): result={in_a[31],8'hFF,1'b1,in_a[21:0]} (quieted); out_invalid=1 if in_a[22]=0.
  - exp=255, man=0, s=0 (+inf): result=32'h7F800000.
  - s=1 and not zero (negative, including -inf): result=32'h7FC00000, out_invalid=1.
  - Priority order: zero, denormal, NaN, +inf, negative.
  - out_special=1 for every case above.
- BUSY:
  - core_en=1 and core_a=registered operand for the entire state.
  - The counter loads 0 on entry and increments each cycle.
  - When counter==CORE_LATENCY, out_result<=core_result at that edge, flags are cleared, and the next state is DONE.
  - Accept-to-out_valid latency: CORE_LATENCY+2 cycles for normal operands, 1 cycle for special operands.
- DONE:
  - out_valid=1.
  - out_result and flags are held stable until out_valid&&out_ready; then the next state is IDLE and out_valid drops the next cycle.
  - in_ready=0 in DONE and BUSY.
- core_en=0 and core_a=0 outside BUSY. The core clears its output register when EN is low, so core_en must never drop mid-operation.
- Back-pressure: out_ready low holds DONE indefinitely; no result is lost or overwritten.
- Reset mid-operation: all state is discarded immediately, outputs go to reset values, and no stale result is presented after release.
- in_valid while not in IDLE is ignored (no capture). in_a need not stay stable after the accept edge.

Optional Feature:
- Macro: FSQRT_SEQ_STATS_EN
- Defined: adds outputs stat_ops[15:0], a count of completed output handshakes, and stat_special[15:0], a count of completed handshakes with out_special=1.
  - Both counters saturate at 16'hFFFF and reset to 0 on RST.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- 4.0: in_a=32'h40800000, core model returns 32'h40000000 after 2 cycles -> out_valid on cycle 4 after accept, out_result=32'h40000000, all flags 0, core_en high 3 cycles.
- -1.0: in_a=32'hBF800000 -> out_valid 1 cycle after accept, out_result=32'h7FC00000, out_invalid=1, out_special=1, core_en never asserted.
- Bypass cases:
  - +inf: in_a=32'h7F800000 -> out_result=32'h7F800000, out_special=1.
  - -0: in_a=32'h80000000 -> out_result=32'h80000000.
  - sNaN: in_a=32'h7F800001 -> out_result=32'h7FC00001, out_invalid=1.
- Denormal: in_a=32'h00000001 -> out_result=32'h00000000, out_denorm=1, out_special=1.
- Back-pressure: out_ready=0 for 10 cycles after out_valid -> out_result held constant, in_ready=0, a new in_valid is not captured; out_ready=1 -> IDLE next cycle.
- Reset: assert RST low during BUSY (cycle 1) -> core_en, out_valid, in_ready fall to 0 asynchronously; after release in_ready=1 and no out_valid without a new operand.

Source files
------------

// File: rtl/fsqrt_op_sequencer.sv
// Control stage around the fsqrt core: classifies operands, bypasses specials, sequences the core.
// Optional stat counters are enabled by defining FSQRT_SEQ_STATS_EN.
module fsqrt_op_sequencer #(
  parameter int CORE_LATENCY = 2,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  output logic        core_en,
  output logic [31:0] core_a,
  input  logic [31:0] core_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_invalid,
  output logic        out_denorm,
  output logic        out_special
`ifdef FSQRT_SEQ_STATS_EN
  ,
  output logic [15:0] stat_ops,
  output logic [15:0] stat_special
`endif
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      opnd_q, opnd_d;
  logic [31:0]      res_q, res_d;
  logic             inv_q, inv_d, den_q, den_d, spc_q, spc_d;

  logic [7:0]  a_exp;
  logic [22:0] a_man;
  logic        a_zero, a_den, a_nan, a_pinf, a_special;
  logic [31:0] a_res;
  logic        a_inv;

  assign a_exp     = in_a[30:23];
  assign a_man     = in_a[22:0];
  assign a_zero    = (a_exp == 8'h00) && (a_man == 23'd0);
  assign a_den     = (a_exp == 8'h00) && (a_man != 23'd0);
  assign a_nan     = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign a_pinf    = (a_exp == 8'hFF) && (a_man == 23'd0) && !in_a[31];
  assign a_special = a_zero || a_den || a_nan || a_pinf || in_a[31];

  // Priority: zero, denormal, NaN, +inf, then any remaining negative.
  always_comb begin
    a_res = 32'h7FC0_0000;
    a_inv = 1'b1;
    if (a_zero) begin
      a_res = in_a;
      a_inv = 1'b0;
    end else if (a_den) begin
      a_res = 32'h0000_0000;
      a_inv = 1'b0;
    end else if (a_nan) begin
      a_res = {in_a[31], 8'hFF, 1'b1, in_a[21:0]};
      a_inv = !in_a[22];
    end else if (a_pinf) begin
      a_res = 32'h7F80_0000;
      a_inv = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    inv_d   = inv_q;
    den_d   = den_q;
    spc_d   = spc_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opnd_d = in_a;
          cnt_d  = '0;
          if (a_special) begin
            state_d = DONE;
            res_d   = a_res;
            inv_d   = a_inv;
            den_d   = a_den;
            spc_d   = 1'b1;
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(CORE_LATENCY)) begin
          state_d = DONE;
          res_d   = core_result;
          inv_d   = 1'b0;
          den_d   = 1'b0;
          spc_d   = 1'b0;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      inv_q   <= 1'b0;
      den_q   <= 1'b0;
      spc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      den_q   <= den_d;
      spc_q   <= spc_d;
    end
  end

  // in_ready is gated by RST so every output reads 0 while reset is held.
  assign in_ready    = RST && (state_q == IDLE);
  assign core_en     = (state_q == BUSY);
  assign core_a      = core_en ? opnd_q : 32'h0;
  assign out_valid   = (state_q == DONE);
  assign out_result  = res_q;
  assign out_invalid = inv_q;
  assign out_denorm  = den_q;
  assign out_special = spc_q;

`ifdef FSQRT_SEQ_STATS_EN
  logic [15:0] ops_q, spc_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ops_q     <= '0;
      spc_cnt_q <= '0;
    end else if (out_valid && out_ready) begin
      if (ops_q != 16'hFFFF) ops_q <= ops_q + 16'd1;
      if (spc_q && (spc_cnt_q != 16'hFFFF)) spc_cnt_q <= spc_cnt_q + 16'd1;
    end
  end

  assign stat_ops     = ops_q;
  assign stat_special = spc_cnt_q;
`endif

endmodule

// File: tb/tb_fsqrt_op_sequencer.sv
// Bench for fsqrt_op_sequencer: timeline reference model, directed plan cases, random traffic.
module tb_fsqrt_op_sequencer;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'h0;
  logic        core_en;
  logic [31:0] core_a;
  logic [31:0] core_result;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic        out_invalid, out_denorm, out_special;
`ifdef FSQRT_SEQ_STATS_EN
  logic [15:0] stat_ops, stat_special;
`endif

  fsqrt_op_sequencer #(.CORE_LATENCY(LAT), .CNT_W(4)) dut (
    .CLK(CLK), .RST(RST),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .core_en(core_en), .core_a(core_a), .core_result(core_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_invalid(out_invalid), .out_denorm(out_denorm), .out_special(out_special)
`ifdef FSQRT_SEQ_STATS_EN
    , .stat_ops(stat_ops), .stat_special(stat_special)
`endif
  );

  always #5 CLK = ~CLK;

  // Core stand-in: result only becomes valid after LAT enabled cycles; cleared when disabled.
  function automatic logic [31:0] core_f(input logic [31:0] a);
    if (a == 32'h4080_0000) return 32'h4000_0000;
    return a * 32'h9E37_79B1;
  endfunction

  int en_cnt;
  always @(posedge CLK or negedge RST) begin
    if (!RST) en_cnt <= 0;
    else en_cnt <= core_en ? en_cnt + 1 : 0;
  end
  assign core_result = (core_en && en_cnt >= LAT) ? core_f(core_a) : 32'hDEAD_BEEF;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Reference classification straight from the operand-class rules.
  task automatic ref_class(input logic [31:0] a, output bit spc, output logic [31:0] r,
                           output bit inv, output bit den);
    int e, m;
    e = int'(a[30:23]);
    m = int'(a[22:0]);
    spc = 1; inv = 0; den = 0;
    if (e == 0 && m == 0) r = a;
    else if (e == 0) begin r = 32'h0; den = 1; end
    else if (e == 255 && m != 0) begin
      r = a | 32'h0040_0000;
      inv = (a[22] == 1'b0);
    end
    else if (e == 255 && a[31] == 1'b0) r = 32'h7F80_0000;
    else if (a[31]) begin r = 32'h7FC0_0000; inv = 1; end
    else begin spc = 0; r = core_f(a); end
  endtask

  // Timeline model: one pending op, known accept cycle and known valid cycle.
  int cyc = 0;
  bit pend = 0;
  int acc_cyc, vld_cyc;
  logic [31:0] e_res, e_op;
  bit e_spc, e_inv, e_den;
  int lat_obs, en_seen;
  bit prev_vld = 0;
  int m_ops = 0, m_spc = 0;

  task automatic step(input bit iv, input logic [31:0] a, input bit ordy);
    bit exp_busy, exp_vld;
    @(negedge CLK);
    cyc++;
    exp_busy = pend && !e_spc && cyc > acc_cyc && cyc < vld_cyc;
    exp_vld  = pend && cyc >= vld_cyc;
    chk("in_ready", 32'(in_ready), 32'(!pend));
    chk("core_en", 32'(core_en), 32'(exp_busy));
    chk("core_a", core_a, exp_busy ? e_op : 32'h0);
    chk("out_valid", 32'(out_valid), 32'(exp_vld));
    if (exp_vld) begin
      chk("out_result", out_result, e_res);
      chk("out_invalid", 32'(out_invalid), 32'(e_inv));
      chk("out_denorm", 32'(out_denorm), 32'(e_den));
      chk("out_special", 32'(out_special), 32'(e_spc));
    end
    if (core_en) en_seen++;
    if (out_valid && !prev_vld) lat_obs = cyc - acc_cyc;
    prev_vld = out_valid;
    in_valid  = iv;
    in_a      = a;
    out_ready = ordy;
    if (!pend && iv) begin
      pend = 1;
      acc_cyc = cyc;
      e_op = a;
      ref_class(a, e_spc, e_res, e_inv, e_den);
      vld_cyc = cyc + (e_spc ? 1 : LAT + 2);
      lat_obs = -1;
      en_seen = 0;
    end else if (exp_vld && ordy) begin
      pend = 0;
      m_ops++;
      if (e_spc) m_spc++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 32'h0, 1);
  endtask

  function automatic logic [31:0] rand_op();
    logic [31:0] man;
    man = $urandom_range(1, 32'h7F_FFFF);
    case ($urandom_range(0, 7))
      0: return {$urandom_range(0, 1) == 1, 31'h0};
      1: return {$urandom_range(0, 1) == 1, 8'h00, man[22:0]};
      2: return {$urandom_range(0, 1) == 1, 8'hFF, man[22:0]};
      3: return 32'h7F80_0000;
      4: return 32'hFF80_0000;
      5: return {1'b1, 8'($urandom_range(1, 254)), man[22:0]};
      default: return {1'b0, 8'($urandom_range(1, 254)), man[22:0]};
    endcase
  endfunction

  initial begin
    bit s, iv, dn;
    logic [31:0] r;

    // Pin the reference classification with hand-computed values.
    ref_class(32'h7F80_0001, s, r, iv, dn);
    chk("model_snan", r, 32'h7FC0_0001); chk("model_snan_inv", 32'(iv), 32'd1);
    ref_class(32'hBF80_0000, s, r, iv, dn);
    chk("model_neg1", r, 32'h7FC0_0000); chk("model_neg1_inv", 32'(iv), 32'd1);
    ref_class(32'h8000_0000, s, r, iv, dn);
    chk("model_negzero", r, 32'h8000_0000);
    ref_class(32'h0000_0001, s, r, iv, dn);
    chk("model_denorm", r, 32'h0); chk("model_denorm_flag", 32'(dn), 32'd1);
    ref_class(32'h4080_0000, s, r, iv, dn);
    chk("model_four_spc", 32'(s), 32'd0); chk("model_four_res", r, 32'h4000_0000);

    // Reset state.
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_core_en", 32'(core_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_result", out_result, 32'h0);
    @(negedge CLK); RST = 1'b1;
    idle(2);

    // 4.0 through the core.
    step(1, 32'h4080_0000, 0);
    for (int i = 0; i < LAT + 2; i++) step(0, 32'h0, 0);
    chk("lat_four", 32'(lat_obs), 32'd4);
    chk("core_en_cycles_four", 32'(en_seen), 32'd3);
    // Back-pressure: 10 held cycles with a competing in_valid.
    for (int i = 0; i < 10; i++) step(1, 32'h3F80_0000, 0);
    chk("held_result", out_result, 32'h4000_0000);
    step(0, 32'h0, 1);
    idle(2);

    // -1.0 bypass.
    step(1, 32'hBF80_0000, 0);
    step(0, 32'h0, 1);
    chk("lat_neg1", 32'(lat_obs), 32'd1);
    chk("core_en_cycles_neg1", 32'(en_seen), 32'd0);
    idle(1);
    step(1, 32'h7F80_0000, 1); idle(2);
    step(1, 32'h8000_0000, 1); idle(2);
    step(1, 32'h7F80_0001, 1); idle(2);
    step(1, 32'h0000_0001, 1); idle(2);

    // Reset during BUSY.
    step(1, 32'h4080_0000, 1);
    step(0, 32'h0, 1);
    #1 RST = 1'b0;
    #1;
    chk("mid_rst_core_en", 32'(core_en), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
    chk("mid_rst_result", out_result, 32'h0);
    pend = 0;
    @(negedge CLK); @(negedge CLK);
    RST = 1'b1;
`ifdef FSQRT_SEQ_STATS_EN
    m_ops = 0; m_spc = 0;
`endif
    idle(LAT + 4);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, rand_op(), $urandom_range(0, 2) != 0);
    for (int i = 0; i < 20; i++) step(0, 32'h0, 1);

`ifdef FSQRT_SEQ_STATS_EN
    chk("stat_ops", 32'(stat_ops), 32'(m_ops));
    chk("stat_special", 32'(stat_special), 32'(m_spc));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
